// File: rtl/dmem_apb_bridge.sv
// Data-side bridge: core load/store port -> two-phase APB transfer, with byte/half lane steering.
// Optional ACCESS-phase watchdog enabled by defining DMEM_BRIDGE_TIMEOUT_EN.
module dmem_apb_bridge #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        size_control,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [31:0]       dwdata,
  output logic              d_stall,
  output logic [31:0]       drdata,
  output logic              d_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [31:0]       pwdata,
  output logic [3:0]        pstrb,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t             state, state_nxt;
  logic               we_q;
  logic [2:0]         size_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic               misaligned;
  logic               timed_out;
  logic               bus;
  logic [7:0]         ld_b;
  logic [15:0]        ld_h;
  logic [31:0]        ld_ext;
  logic [31:0]        st_data;
  logic [3:0]         st_strb;

  // Reserved funct3 encodings are reported as misaligned so they never reach the bus.
  always_comb begin
    case (size_control)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = daddr[0];
      3'b010:         misaligned = |daddr[1:0];
      default:        misaligned = 1'b1;
    endcase
  end

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (state == SETUP)  cnt <= '0;
    else if (state == ACCESS) cnt <= cnt + 1'b1;
  end

  assign timed_out = (state == ACCESS) && !pready && (cnt == CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timed_out      = 1'b0;
`endif

  always_comb begin
    ld_b = prdata[8*addr_q[1:0] +: 8];
    ld_h = addr_q[1] ? prdata[31:16] : prdata[15:0];
    case (size_q)
      3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
      3'b100:  ld_ext = {24'h0, ld_b};
      3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
      3'b101:  ld_ext = {16'h0, ld_h};
      default: ld_ext = prdata;
    endcase
  end

  always_comb begin
    case (size_q[1:0])
      2'b00: begin
        st_data = {4{wdata_q[7:0]}};
        st_strb = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        st_data = {2{wdata_q[15:0]}};
        st_strb = 4'b0011 << addr_q[1:0];
      end
      default: begin
        st_data = wdata_q;
        st_strb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (d_req) state_nxt = misaligned ? DONE : SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (pready || timed_out) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 3'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      drdata  <= '0;
      d_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && d_req) begin
        we_q    <= d_we;
        size_q  <= size_control;
        addr_q  <= daddr;
        wdata_q <= dwdata;
        if (misaligned) begin
          drdata <= '0;
          d_err  <= 1'b1;
        end
      end
      if (state == ACCESS) begin
        if (pready) begin
          drdata <= we_q ? 32'h0 : ld_ext;
          d_err  <= pslverr;
        end else if (timed_out) begin
          drdata <= '0;
          d_err  <= 1'b1;
        end
      end
    end
  end

  // Bus outputs derive only from captured state, so they stay stable across SETUP/ACCESS.
  assign bus     = (state == SETUP) || (state == ACCESS);
  assign psel    = bus;
  assign penable = (state == ACCESS);
  assign pwrite  = bus && we_q;
  assign paddr   = bus ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign pwdata  = (bus && we_q) ? st_data : 32'h0;
  assign pstrb   = (bus && we_q) ? st_strb : 4'h0;
  assign d_stall = d_req && (state != DONE);

endmodule

// File: tb/tb_dmem_apb_bridge.sv
// Directed bench for dmem_apb_bridge: driver queues expected responses, monitors compare at negedge.
module tb_dmem_apb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_req, d_we;
  logic [2:0]  size_control;
  logic [31:0] daddr, dwdata;
  logic        d_stall;
  logic [31:0] drdata;
  logic        d_err;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;

  dmem_apb_bridge #(.ADDR_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .d_req(d_req), .d_we(d_we), .size_control(size_control),
    .daddr(daddr), .dwdata(dwdata), .d_stall(d_stall), .drdata(drdata), .d_err(d_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rdata;
    int          lat;
  } resp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } bus_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  int    compared = 0;
  int    mismatched = 0;
  int    cyc = 0;
  int    start_cyc = 0;
  int    s_waits = 0;
  logic  s_err = 1'b0;
  int    acc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // APB slave: pready rises after s_waits low ACCESS cycles.
  always @(posedge clk) begin
    #1;
    if (psel && penable) begin
      pready  = (acc >= s_waits);
      pslverr = pready ? s_err : 1'b0;
      acc++;
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
      acc     = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (d_req && !d_stall) begin
        if (resp_q.size() == 0) begin
          chk("resp_unexpected", 32'd1, 32'd0);
        end else begin
          resp_t r;
          r = resp_q.pop_front();
          chk("d_err", {31'h0, d_err}, {31'h0, r.err});
          if (r.chk_rdata) chk("drdata", drdata, r.rdata);
          chk("latency", 32'(cyc - start_cyc), 32'(r.lat));
        end
      end
      if (psel && penable && pready) begin
        if (bus_q.size() == 0) begin
          chk("bus_unexpected", 32'd1, 32'd0);
        end else begin
          bus_t b;
          b = bus_q.pop_front();
          chk("pwrite", {31'h0, pwrite}, {31'h0, b.wr});
          chk("paddr", paddr, b.addr);
          chk("pwdata", pwdata, b.wdata);
          chk("pstrb", {28'h0, pstrb}, {28'h0, b.strb});
        end
      end
    end
  end

  task automatic xfer(input logic we, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input int waits,
                      input logic serr, input logic [31:0] exp_rd, input logic exp_err,
                      input logic chk_rd, input int exp_lat, input logic on_bus,
                      input logic [31:0] exp_pwdata, input logic [3:0] exp_strb);
    resp_t r;
    bus_t  b;
    int    n;
    logic  done;
    r.rdata = exp_rd; r.err = exp_err; r.chk_rdata = chk_rd; r.lat = exp_lat;
    resp_q.push_back(r);
    if (on_bus) begin
      b.wr = we; b.addr = {a[31:2], 2'b00};
      b.wdata = we ? exp_pwdata : 32'h0;
      b.strb  = we ? exp_strb : 4'h0;
      bus_q.push_back(b);
    end
    @(posedge clk); #1;
    d_we = we; size_control = sz; daddr = a; dwdata = wd;
    prdata = rd; s_waits = waits; s_err = serr;
    start_cyc = cyc;
    d_req = 1'b1;
    n = 0; done = 1'b0;
    while (!done && n < 60) begin
      @(negedge clk);
      if (!d_stall) done = 1'b1;
      n++;
    end
    if (!done) chk("stall_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; d_req = 1'b0; d_we = 1'b0; size_control = 3'b0;
    daddr = '0; dwdata = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_psel",    {31'h0, psel},    32'h0);
    chk("rst_penable", {31'h0, penable}, 32'h0);
    chk("rst_pwrite",  {31'h0, pwrite},  32'h0);
    chk("rst_paddr",   paddr,            32'h0);
    chk("rst_pwdata",  pwdata,           32'h0);
    chk("rst_pstrb",   {28'h0, pstrb},   32'h0);
    chk("rst_drdata",  drdata,           32'h0);
    chk("rst_d_err",   {31'h0, d_err},   32'h0);
    chk("rst_d_stall", {31'h0, d_stall}, 32'h0);

    // stores
    xfer(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, 32'h0, 0, 0, 3, 1, 32'hDEADBEEF, 4'b1111);
    xfer(1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 0, 0, 32'h0, 0, 0, 3, 1, 32'hA5A5A5A5, 4'b1000);
    xfer(1, 3'b001, 32'h12, 32'h1234BEEF, 32'h0, 0, 0, 32'h0, 0, 0, 3, 1, 32'hBEEFBEEF, 4'b1100);
    // loads with sign/zero extension
    xfer(0, 3'b000, 32'h12, 32'h0, 32'h80F10000, 0, 0, 32'hFFFFFFF1, 0, 1, 3, 1, 32'h0, 4'h0);
    xfer(0, 3'b100, 32'h12, 32'h0, 32'h80F10000, 0, 0, 32'h000000F1, 0, 1, 3, 1, 32'h0, 4'h0);
    xfer(0, 3'b001, 32'h12, 32'h0, 32'h80F10000, 0, 0, 32'hFFFF80F1, 0, 1, 3, 1, 32'h0, 4'h0);
    xfer(0, 3'b101, 32'h12, 32'h0, 32'h80F10000, 0, 0, 32'h000080F1, 0, 1, 3, 1, 32'h0, 4'h0);
    xfer(0, 3'b000, 32'h11, 32'h0, 32'h00007F00, 0, 0, 32'h0000007F, 0, 1, 3, 1, 32'h0, 4'h0);
    // wait states then slave error
    xfer(0, 3'b010, 32'h20, 32'h0, 32'h12345678, 3, 1, 32'h12345678, 1, 1, 6, 1, 32'h0, 4'h0);
    // misaligned / reserved sizes: no bus cycle
    xfer(0, 3'b001, 32'h01, 32'h0, 32'h0, 0, 0, 32'h0, 1, 1, 1, 0, 32'h0, 4'h0);
    xfer(0, 3'b010, 32'h22, 32'h0, 32'h0, 0, 0, 32'h0, 1, 1, 1, 0, 32'h0, 4'h0);
    xfer(1, 3'b011, 32'h40, 32'h0, 32'h0, 0, 0, 32'h0, 1, 1, 1, 0, 32'h0, 4'h0);

    // reset pulsed during ACCESS
    @(posedge clk); #1;
    d_we = 1'b1; size_control = 3'b010; daddr = 32'h30; dwdata = 32'h11111111;
    s_waits = 20; s_err = 1'b0; d_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_access", {30'h0, psel, penable}, 32'h3);
    #4 rst = 1'b1; d_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_psel",    {31'h0, psel},    32'h0);
    chk("post_rst_penable", {31'h0, penable}, 32'h0);
    chk("post_rst_paddr",   paddr,            32'h0);
    xfer(1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 0, 0, 32'h0, 0, 0, 3, 1, 32'hCAFEF00D, 4'b1111);

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    xfer(0, 3'b010, 32'h50, 32'h0, 32'h0, 100, 0, 32'h0, 1, 1, 18, 0, 32'h0, 4'h0);
`endif

    repeat (3) @(posedge clk);
    chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
    chk("bus_q_empty",  32'(bus_q.size()),  32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
